// File: rtl/vx_fetch_ibuffer_if.sv
// Fetch -> ibuffer -> decode handshake bundle, plus the per-warp dequeue pulses fed back to fetch.
interface vx_fetch_ibuffer_if #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int UUID_WIDTH  = 44
);
    localparam int WID_W = $clog2(NUM_WARPS);

    logic                   in_valid;
    logic [UUID_WIDTH-1:0]  in_uuid;
    logic [WID_W-1:0]       in_wid;
    logic [NUM_THREADS-1:0] in_tmask;
    logic [PC_WIDTH-1:0]    in_PC;
    logic [INSTR_WIDTH-1:0] in_instr;
    logic                   in_ready;

    logic                   out_valid;
    logic [UUID_WIDTH-1:0]  out_uuid;
    logic [WID_W-1:0]       out_wid;
    logic [NUM_THREADS-1:0] out_tmask;
    logic [PC_WIDTH-1:0]    out_PC;
    logic [INSTR_WIDTH-1:0] out_instr;
    logic                   out_ready;

    logic [NUM_WARPS-1:0]   ibuf_pop;

    modport master (
        output in_valid, in_uuid, in_wid, in_tmask, in_PC, in_instr, out_ready,
        input  in_ready, out_valid, out_uuid, out_wid, out_tmask, out_PC, out_instr, ibuf_pop
    );

    modport slave (
        input  in_valid, in_uuid, in_wid, in_tmask, in_PC, in_instr, out_ready,
        output in_ready, out_valid, out_uuid, out_wid, out_tmask, out_PC, out_instr, ibuf_pop
    );
endinterface

// File: rtl/vx_fetch_ibuffer.sv
// Per-warp instruction FIFOs between fetch and decode, drained one entry per cycle round-robin.
module vx_fetch_ibuffer #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int IBUF_SIZE   = 4,
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int UUID_WIDTH  = 44
) (
    input  logic             clk,
    input  logic             reset,
    vx_fetch_ibuffer_if.slave bus
);
    localparam int WID_W = $clog2(NUM_WARPS);
    localparam int PTR_W = $clog2(IBUF_SIZE);
    localparam int CNT_W = $clog2(IBUF_SIZE + 1);

    typedef struct packed {
        logic [UUID_WIDTH-1:0]  uuid;
        logic [NUM_THREADS-1:0] tmask;
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    entry_t                              in_ent;
    entry_t [NUM_WARPS-1:0]              head;
    logic   [NUM_WARPS-1:0][CNT_W-1:0]   cnt;
    logic   [NUM_WARPS-1:0]              cand;
    logic   [NUM_WARPS-1:0]              pop_oh;
    logic   [WID_W-1:0]                  rr_last_q, rr_last_d, grant, arb_idx;
    logic                                arb_found;
    logic                                push, pop;

    assign in_ent = '{uuid: bus.in_uuid, tmask: bus.in_tmask, pc: bus.in_PC, instr: bus.in_instr};

    // Full check uses only registered counts, so in_ready never depends on out_ready.
    assign bus.in_ready = (cnt[bus.in_wid] != CNT_W'(IBUF_SIZE));
    assign push         = bus.in_valid & bus.in_ready;
    assign pop          = bus.out_valid & bus.out_ready;

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
        logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
        logic [CNT_W-1:0] count_q;
        entry_t           mem_q [IBUF_SIZE];
        logic             push_w, pop_w;

        assign push_w = push && (bus.in_wid == WID_W'(w));
        assign pop_w  = pop && (grant == WID_W'(w));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                for (int i = 0; i < IBUF_SIZE; i++) mem_q[i] <= '0;
            end else begin
                if (push_w) begin
                    mem_q[wr_ptr_q] <= in_ent;
                    wr_ptr_q        <= wr_ptr_q + 1'b1;
                end
                if (pop_w) rd_ptr_q <= rd_ptr_q + 1'b1;
                if (push_w != pop_w) count_q <= push_w ? count_q + 1'b1 : count_q - 1'b1;
            end
        end

        assign cnt[w]    = count_q;
        assign cand[w]   = (count_q != '0);
        assign head[w]   = mem_q[rd_ptr_q];
        assign pop_oh[w] = pop_w;
    end

    // First non-empty warp after the last granted one, wrapping.
    always_comb begin
        grant     = '0;
        arb_idx   = '0;
        arb_found = 1'b0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            arb_idx = WID_W'((int'(rr_last_q) + i) % NUM_WARPS);
            if (!arb_found && cand[arb_idx]) begin
                grant     = arb_idx;
                arb_found = 1'b1;
            end
        end
    end

    assign rr_last_d = pop ? grant : rr_last_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_last_q <= WID_W'(NUM_WARPS - 1);
        else       rr_last_q <= rr_last_d;
    end

    assign bus.out_valid = |cand;
    assign bus.out_wid   = grant;
    assign bus.out_uuid  = head[grant].uuid;
    assign bus.out_tmask = head[grant].tmask;
    assign bus.out_PC    = head[grant].pc;
    assign bus.out_instr = head[grant].instr;
    assign bus.ibuf_pop  = pop_oh;
endmodule
